// File: rtl/mem_burst_client_if.sv
// Bus bundle for mem_burst_client: command channel, arbiter handshake,
// shared-memory port, producer write stream and consumer read stream.
interface mem_burst_client_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [4:0]        cmd_len;
    // arbiter channel
    logic              arb_request;
    logic              arb_grant;
    // shared-memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rd_data;
    // producer write stream
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    // consumer read stream
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;

    // burst client side
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  arb_grant, mem_rd_data, wr_data, wr_valid,
        output cmd_ready, arb_request, mem_addr, mem_wr_data,
        output mem_wr_en, mem_rd_en, wr_ready, rd_data, rd_valid, done
    );

    // environment side: command source, arbiter, memory, producer, consumer
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output arb_grant, mem_rd_data, wr_data, wr_valid,
        input  cmd_ready, arb_request, mem_addr, mem_wr_data,
        input  mem_wr_en, mem_rd_en, wr_ready, rd_data, rd_valid, done
    );
endinterface

// File: rtl/mem_burst_client.sv
// Burst client for a shared memory behind an arbiter. Accepts one command
// at a time, requests the memory channel, streams up to 16 words one per
// granted cycle, then releases the channel with a one-cycle done pulse.
module mem_burst_client #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_burst_client_if.master  bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_XFER    = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam logic [4:0] MAX_LEN = 5'd16;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [4:0]        r_remaining;
    logic              r_rd_valid;

    logic              w_cmd_fire;
    logic [4:0]        w_len_clip;
    logic              w_in_xfer;
    logic              w_words_left;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_fire;
    logic [DATA_W-1:0] w_wr_data;

    // Lengths above the 16-word maximum are clipped rather than rejected.
    assign w_len_clip   = (bus.cmd_len > MAX_LEN) ? MAX_LEN : bus.cmd_len;
    assign w_cmd_fire   = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_in_xfer    = (r_state == S_XFER);
    assign w_words_left = (r_remaining != 5'd0);

    // A word moves only with grant present; writes also wait for producer data.
    assign w_wr_fire = w_in_xfer && r_write && bus.arb_grant && bus.wr_valid && w_words_left;
    assign w_rd_fire = w_in_xfer && !r_write && bus.arb_grant && w_words_left;
    assign w_fire    = w_wr_fire || w_rd_fire;

    assign w_wr_data = bus.wr_data;

    assign bus.cmd_ready   = (r_state == S_IDLE);
    assign bus.arb_request = (r_state == S_REQ) || (r_state == S_XFER) || (r_state == S_DRAIN);
    assign bus.done        = (r_state == S_RELEASE);
    assign bus.mem_addr    = r_addr;
    assign bus.mem_wr_data = w_wr_data;
    assign bus.mem_wr_en   = w_wr_fire;
    assign bus.mem_rd_en   = w_rd_fire;
    assign bus.wr_ready    = w_wr_fire;
    assign bus.rd_data     = bus.mem_rd_data;
    assign bus.rd_valid    = r_rd_valid;

    // Next-state selection for the burst sequencer.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    w_state_nxt = (w_len_clip == 5'd0) ? S_RELEASE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.arb_grant) begin
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                if (w_fire && (r_remaining == 5'd1)) begin
                    // Reads still have one word in flight from memory.
                    w_state_nxt = r_write ? S_RELEASE : S_DRAIN;
                end
            end
            S_DRAIN:   w_state_nxt = S_RELEASE;
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // State, burst context and the registered read-valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_remaining <= 5'd0;
            r_rd_valid  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state    <= w_state_nxt;
            r_rd_valid <= w_rd_fire;
            if (w_cmd_fire) begin
                r_write     <= bus.cmd_write;
                r_addr      <= bus.cmd_addr;
                r_remaining <= w_len_clip;
            end else if (w_fire) begin
                // Address wraps naturally at the top of the address space.
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_burst_client.sv
// Scoreboard bench for mem_burst_client: stimulus pushes expected strobes,
// read data and done pulses; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mem_burst_client;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } strobe_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int acc_cyc = 0;
    int wr_idx  = 0;
    int exp_done = 0;

    strobe_t     exp_strobe[$];
    logic [15:0] exp_rd[$];
    int          strobe_log[$];
    int          rv_log[$];
    int          exp_sj[$];

    mem_burst_client_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_burst_client #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // memory model: read data is a fixed function of the address, one cycle late
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.mem_rd_data <= 16'h0000;
        else        bus.mem_rd_data <= bus.mem_rd_en ? (bus.mem_addr ^ 16'h5A5A) : 16'h0000;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // monitor: compare every DUT output event against the scoreboard queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_wr_en || bus.mem_rd_en) begin
                strobe_t s;
                check("single_strobe", {31'b0, bus.mem_wr_en & bus.mem_rd_en}, 32'd0);
                check("strobe_granted", {31'b0, bus.arb_grant}, 32'd1);
                check("strobe_arb_req", {31'b0, bus.arb_request}, 32'd1);
                check("strobe_expected", {31'b0, exp_strobe.size() != 0}, 32'd1);
                if (exp_strobe.size() != 0) begin
                    s = exp_strobe.pop_front();
                    check("strobe_kind", {31'b0, bus.mem_wr_en}, {31'b0, s.wr});
                    check("strobe_addr", {16'b0, bus.mem_addr}, {16'b0, s.addr});
                    if (s.wr) check("strobe_wdata", {16'b0, bus.mem_wr_data}, {16'b0, s.data});
                end
                strobe_log.push_back(cyc);
            end
            if (bus.rd_valid) begin
                check("rd_expected", {31'b0, exp_rd.size() != 0}, 32'd1);
                if (exp_rd.size() != 0) check("rd_data", {16'b0, bus.rd_data}, {16'b0, exp_rd.pop_front()});
                rv_log.push_back(cyc);
            end
            if (bus.done) begin
                check("done_expected", {31'b0, exp_done > 0}, 32'd1);
                check("done_arb_low", {31'b0, bus.arb_request}, 32'd0);
                if (exp_done > 0) exp_done--;
            end
        end
    end

    // called at posedge+1 with cmd fields; returns at posedge+1 of the cycle after acceptance
    task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [4:0] len);
        int guard;
        guard = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        @(negedge clk);
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_accept", {31'b0, bus.cmd_ready}, 32'd1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    // one complete burst; exp_sj holds the expected strobe cycles relative to acceptance
    task automatic run_burst(input string tag, input logic wr, input logic [15:0] addr,
                             input logic [4:0] len, input int n_xfer, input int done_j,
                             input logic [31:0] vmask, input logic [31:0] gmask);
        logic [15:0] a;
        strobe_t     s;
        a = addr;
        for (int i = 0; i < n_xfer; i++) begin
            s.wr   = wr;
            s.addr = a;
            s.data = wr ? (16'hD000 + 16'(i)) : 16'h0000;
            exp_strobe.push_back(s);
            if (!wr) exp_rd.push_back(a ^ 16'h5A5A);
            a = a + 16'd1;
        end
        exp_done++;
        strobe_log.delete();
        rv_log.delete();
        wr_idx        = 0;
        bus.wr_valid  = vmask[0];
        bus.arb_grant = gmask[0];
        bus.wr_data   = 16'hD000;
        send_cmd(wr, addr, len);
        for (int j = 1; j <= done_j + 1; j++) begin
            bus.wr_valid  = (j < 32) ? vmask[j] : 1'b1;
            bus.arb_grant = (j < 32) ? gmask[j] : 1'b1;
            bus.wr_data   = 16'hD000 + 16'(wr_idx);
            @(negedge clk);
            check({tag, "_arb_request"}, {31'b0, bus.arb_request}, {31'b0, (len != 5'd0) && (j < done_j)});
            check({tag, "_done"}, {31'b0, bus.done}, {31'b0, j == done_j});
            check({tag, "_cmd_ready"}, {31'b0, bus.cmd_ready}, {31'b0, j == done_j + 1});
            if (bus.wr_valid && bus.wr_ready) wr_idx++;
            @(posedge clk); #1;
        end
        check({tag, "_n_strobes"}, strobe_log.size(), exp_sj.size());
        for (int k = 0; k < exp_sj.size(); k++) begin
            if (k < strobe_log.size()) check({tag, "_strobe_cycle"}, strobe_log[k] - acc_cyc, exp_sj[k]);
        end
        if (!wr) begin
            check({tag, "_n_rd_valid"}, rv_log.size(), exp_sj.size());
            for (int k = 0; k < exp_sj.size(); k++) begin
                if (k < rv_log.size()) check({tag, "_rd_valid_cycle"}, rv_log[k] - acc_cyc, exp_sj[k] + 1);
            end
        end
        check({tag, "_leftover"}, exp_strobe.size() + exp_rd.size() + exp_done, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 16'h0000;
        bus.cmd_len   = 5'd0;
        bus.arb_grant = 1'b0;
        bus.wr_data   = 16'h0000;
        bus.wr_valid  = 1'b0;

        // reset state
        #2;
        check("rst_arb_request", {31'b0, bus.arb_request}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_mem_wr_en", {31'b0, bus.mem_wr_en}, 32'd0);
        check("rst_mem_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
        check("rst_wr_ready", {31'b0, bus.wr_ready}, 32'd0);
        check("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
        check("rst_mem_addr", {16'b0, bus.mem_addr}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // write len 4 at 0x0010, immediate grant, producer always ready
        exp_sj = '{2, 3, 4, 5};
        run_burst("wr4", 1'b1, 16'h0010, 5'd4, 4, 6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // read len 3 across the address wrap
        exp_sj = '{2, 3, 4};
        run_burst("rd3_wrap", 1'b0, 16'hFFFE, 5'd3, 3, 6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // write len 4, producer idle for 3 cycles on the second word
        exp_sj = '{2, 6, 7, 8};
        run_burst("wr4_stall", 1'b1, 16'h0020, 5'd4, 4, 9, 32'hFFFF_FFC7, 32'hFFFF_FFFF);

        // read len 6, grant withheld 5 cycles then dropped 2 cycles mid-burst
        exp_sj = '{7, 8, 11, 12, 13, 14};
        run_burst("rd6_grant", 1'b0, 16'h0300, 5'd6, 6, 16, 32'hFFFF_FFFF, 32'hFFFF_F9C0);

        // zero-length command
        exp_sj = {};
        run_burst("len0", 1'b1, 16'h0400, 5'd0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // oversize command clipped to 16
        exp_sj = {};
        for (int i = 2; i <= 17; i++) exp_sj.push_back(i);
        run_burst("len20", 1'b1, 16'h0500, 5'd20, 16, 18, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // reset during write len 8 after 3 words
        strobe_log.delete();
        rv_log.delete();
        for (int i = 0; i < 3; i++) begin
            strobe_t s;
            s.wr   = 1'b1;
            s.addr = 16'h0100 + 16'(i);
            s.data = 16'hD000 + 16'(i);
            exp_strobe.push_back(s);
        end
        wr_idx        = 0;
        bus.wr_valid  = 1'b1;
        bus.arb_grant = 1'b1;
        bus.wr_data   = 16'hD000;
        send_cmd(1'b1, 16'h0100, 5'd8);
        for (int j = 1; j <= 4; j++) begin
            bus.wr_data = 16'hD000 + 16'(wr_idx);
            @(negedge clk);
            if (bus.wr_valid && bus.wr_ready) wr_idx++;
            @(posedge clk); #1;
        end
        bus.wr_data = 16'hD000 + 16'(wr_idx);
        #1;
        check("mid_burst_live", {31'b0, bus.mem_wr_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_arb_request", {31'b0, bus.arb_request}, 32'd0);
        check("async_rst_mem_wr_en", {31'b0, bus.mem_wr_en}, 32'd0);
        check("async_rst_wr_ready", {31'b0, bus.wr_ready}, 32'd0);
        check("async_rst_done", {31'b0, bus.done}, 32'd0);
        check("async_rst_mem_addr", {16'b0, bus.mem_addr}, 32'd0);
        check("async_rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        for (int j = 0; j < 3; j++) begin
            check("post_rst_no_done", {31'b0, bus.done}, 32'd0);
            check("post_rst_no_arb", {31'b0, bus.arb_request}, 32'd0);
            @(negedge clk);
        end
        check("rst_abandon_writes", strobe_log.size(), 32'd3);
        check("rst_abandon_leftover", exp_strobe.size() + exp_done, 32'd0);
        @(posedge clk); #1;

        // new command accepted after reset
        exp_sj = '{2};
        run_burst("after_rst_rd1", 1'b0, 16'h0042, 5'd1, 1, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
